// File: rtl/bf_io_ctrl.sv
// CPU-side I/O sequencer: one-byte reads from the input queue device and FIFO-buffered
// writes to the output sink, each device driven by its own strobe FSM.
//
// state    | meaning
// I_IDLE   | waiting for rd_req; captures dev_in_data on request
// I_DONE   | rd_done pulse, rd_data valid
// I_STRB   | dev_in_setready high, input device advances
// I_GAP    | setready low before another read may start
// O_IDLE   | waiting for FIFO data; pops head into dev_out_data
// O_SETUP  | data setup cycle before the capture strobe
// O_STRB   | dev_out_ready high, sink captures dev_out_data
// O_GAP    | ready low before the next byte
module bf_io_ctrl #(
  parameter int DATA_W        = 8,
  parameter int OBUF_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_full,
  output logic              idle,
  input  logic [DATA_W-1:0] dev_in_data,
  output logic              dev_in_setready,
  output logic [DATA_W-1:0] dev_out_data,
  output logic              dev_out_ready
);
  localparam int PW      = $clog2(OBUF_DEPTH);
  localparam int CW      = PW + 1;
  localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(CNT_MAX) + 1;
  localparam logic [TW-1:0] STRB_LAST = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(OBUF_DEPTH);

  typedef enum logic [1:0] {I_IDLE, I_DONE, I_STRB, I_GAP} i_state_t;
  typedef enum logic [1:0] {O_IDLE, O_SETUP, O_STRB, O_GAP} o_state_t;

  i_state_t i_state, i_next;
  o_state_t o_state, o_next;
  logic [TW-1:0] i_tmr, o_tmr;

  logic [DATA_W-1:0] mem [OBUF_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  // ---------------- input path ----------------
  always_ff @(posedge clk) begin
    if (rst) i_state <= I_IDLE;
    else     i_state <= i_next;
  end

  always_comb begin
    i_next = i_state;
    case (i_state)
      I_IDLE:  if (rd_req) i_next = I_DONE;
      I_DONE:  i_next = I_STRB;
      I_STRB:  if (i_tmr == STRB_LAST) i_next = I_GAP;
      I_GAP:   if (i_tmr == GAP_LAST) i_next = I_IDLE;
      default: i_next = I_IDLE;
    endcase
  end

  always_comb begin
    rd_done         = (i_state == I_DONE);
    dev_in_setready = (i_state == I_STRB);
  end

  // Timer restarts whenever the state changes, so each phase counts from zero.
  always_ff @(posedge clk) begin
    if (rst || i_state != i_next) i_tmr <= '0;
    else                          i_tmr <= i_tmr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          rd_data <= '0;
    else if (i_state == I_IDLE && rd_req) rd_data <= dev_in_data;
  end

  // ---------------- output FIFO ----------------
  assign wr_full = (count == FULL_CNT);
  assign wr_ack  = !wr_full;
  assign push    = wr_req && !wr_full;
  assign pop     = (o_state == O_IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- output path ----------------
  always_ff @(posedge clk) begin
    if (rst) o_state <= O_IDLE;
    else     o_state <= o_next;
  end

  always_comb begin
    o_next = o_state;
    case (o_state)
      O_IDLE:  if (count != '0) o_next = O_SETUP;
      O_SETUP: o_next = O_STRB;
      O_STRB:  if (o_tmr == STRB_LAST) o_next = O_GAP;
      O_GAP:   if (o_tmr == GAP_LAST) o_next = O_IDLE;
      default: o_next = O_IDLE;
    endcase
  end

  always_comb begin
    dev_out_ready = (o_state == O_STRB);
  end

  always_ff @(posedge clk) begin
    if (rst || o_state != o_next) o_tmr <= '0;
    else                          o_tmr <= o_tmr + 1'b1;
  end

  // Holds the last byte sent between transfers.
  always_ff @(posedge clk) begin
    if (rst)      dev_out_data <= '0;
    else if (pop) dev_out_data <= mem[rd_ptr];
  end

  assign idle = (i_state == I_IDLE) && (o_state == O_IDLE) && (count == '0)
                && !rd_req && !wr_req;

endmodule
